// File: rtl/tiny_rv_rr_hz.sv
// tiny_rv_rr_hz: register-read stage with operand forwarding, load-use hazard bubbles and a hazard counter
module tiny_rv_rr_hz #(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_pipe_stall,
  input  logic                    i_pipe_flush,
  input  logic                    decode_valid,
  input  logic [XLEN-1:0]         decode_pc,
  input  logic [XLEN-1:0]         decode_imm32,
  input  logic [31:0]             decode_inst,
  input  logic [6:0]              decode_opcode,
  input  logic [2:0]              decode_funct3,
  input  logic [6:0]              decode_funct7,
  input  logic [4:0]              decode_rs1,
  input  logic [4:0]              decode_rs2,
  input  logic [4:0]              decode_rd,
  input  logic                    decode_uses_rs1,
  input  logic                    decode_uses_rs2,
  output logic [4:0]              read_p1,
  output logic [4:0]              read_p2,
  input  logic [XLEN-1:0]         data_p1,
  input  logic [XLEN-1:0]         data_p2,
  input  logic [NUM_FWD-1:0]      fwd_valid,
  input  logic [NUM_FWD-1:0]      fwd_ready,
  input  logic [NUM_FWD*5-1:0]    fwd_reg,
  input  logic [NUM_FWD*XLEN-1:0] fwd_val,
  output logic                    o_decode_stall,
  output logic                    rr_valid,
  output logic [XLEN-1:0]         rr_pc,
  output logic [31:0]             rr_inst,
  output logic [6:0]              rr_opcode,
  output logic [2:0]              rr_funct3,
  output logic [6:0]              rr_funct7,
  output logic [4:0]              rr_rd,
  output logic [XLEN-1:0]         rr_imm32,
  output logic [XLEN-1:0]         rr_rs1,
  output logic [XLEN-1:0]         rr_rs2,
  output logic [31:0]             rr_hazard_cnt
);
  logic [XLEN-1:0] op1, op2;
  logic rdy1, rdy2, hazard, load, zero;
  assign read_p1 = decode_rs1;
  assign read_p2 = decode_rs2;
  // Scan oldest to youngest so the lowest matching index wins; x0 overrides everything.
  always_comb begin
    op1 = data_p1;
    op2 = data_p2;
    rdy1 = 1'b1;
    rdy2 = 1'b1;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (fwd_valid[k] && fwd_reg[5*k +: 5] == decode_rs1) begin
        op1 = fwd_val[XLEN*k +: XLEN];
        rdy1 = fwd_ready[k];
      end
      if (fwd_valid[k] && fwd_reg[5*k +: 5] == decode_rs2) begin
        op2 = fwd_val[XLEN*k +: XLEN];
        rdy2 = fwd_ready[k];
      end
    end
    if (decode_rs1 == 5'd0) begin
      op1 = '0;
      rdy1 = 1'b1;
    end
    if (decode_rs2 == 5'd0) begin
      op2 = '0;
      rdy2 = 1'b1;
    end
  end
  assign hazard = decode_valid && ((decode_uses_rs1 && !rdy1) || (decode_uses_rs2 && !rdy2));
  assign o_decode_stall = !i_pipe_flush && (i_pipe_stall || hazard);
  assign load = i_reset || i_pipe_flush || !i_pipe_stall;
  assign zero = i_reset || i_pipe_flush || hazard || !decode_valid;
  always_ff @(posedge i_clk) begin
    if (load) begin
      rr_valid  <= !zero;
      rr_pc     <= zero ? '0 : decode_pc;
      rr_inst   <= zero ? '0 : decode_inst;
      rr_opcode <= zero ? '0 : decode_opcode;
      rr_funct3 <= zero ? '0 : decode_funct3;
      rr_funct7 <= zero ? '0 : decode_funct7;
      rr_rd     <= zero ? '0 : decode_rd;
      rr_imm32  <= zero ? '0 : decode_imm32;
      rr_rs1    <= zero ? '0 : op1;
      rr_rs2    <= zero ? '0 : op2;
    end
    if (i_reset)
      rr_hazard_cnt <= '0;
    else if (!i_pipe_flush && !i_pipe_stall && hazard && rr_hazard_cnt != '1)
      rr_hazard_cnt <= rr_hazard_cnt + 32'd1;
  end
endmodule

// File: tb/tb_tiny_rv_rr_hz.sv
// tb_tiny_rv_rr_hz: directed checks of forwarding, hazard bubbles, stall/flush priority and counter saturation
module tb_tiny_rv_rr_hz;
  localparam int XLEN = 32;
  localparam int NF = 2;
  logic i_clk = 1'b0;
  logic i_reset, i_pipe_stall, i_pipe_flush, decode_valid;
  logic [XLEN-1:0] decode_pc, decode_imm32, data_p1, data_p2;
  logic [31:0] decode_inst;
  logic [6:0] decode_opcode, decode_funct7;
  logic [2:0] decode_funct3;
  logic [4:0] decode_rs1, decode_rs2, decode_rd, read_p1, read_p2;
  logic decode_uses_rs1, decode_uses_rs2;
  logic [NF-1:0] fwd_valid, fwd_ready;
  logic [NF*5-1:0] fwd_reg;
  logic [NF*XLEN-1:0] fwd_val;
  logic o_decode_stall, rr_valid;
  logic [XLEN-1:0] rr_pc, rr_imm32, rr_rs1, rr_rs2;
  logic [31:0] rr_inst, rr_hazard_cnt;
  logic [6:0] rr_opcode, rr_funct7;
  logic [2:0] rr_funct3;
  logic [4:0] rr_rd;
  int total = 0;
  int bad = 0;

  tiny_rv_rr_hz #(.XLEN(XLEN), .NUM_FWD(NF)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_pipe_stall(i_pipe_stall), .i_pipe_flush(i_pipe_flush),
    .decode_valid(decode_valid), .decode_pc(decode_pc), .decode_imm32(decode_imm32),
    .decode_inst(decode_inst), .decode_opcode(decode_opcode), .decode_funct3(decode_funct3),
    .decode_funct7(decode_funct7), .decode_rs1(decode_rs1), .decode_rs2(decode_rs2),
    .decode_rd(decode_rd), .decode_uses_rs1(decode_uses_rs1), .decode_uses_rs2(decode_uses_rs2),
    .read_p1(read_p1), .read_p2(read_p2), .data_p1(data_p1), .data_p2(data_p2),
    .fwd_valid(fwd_valid), .fwd_ready(fwd_ready), .fwd_reg(fwd_reg), .fwd_val(fwd_val),
    .o_decode_stall(o_decode_stall), .rr_valid(rr_valid), .rr_pc(rr_pc), .rr_inst(rr_inst),
    .rr_opcode(rr_opcode), .rr_funct3(rr_funct3), .rr_funct7(rr_funct7), .rr_rd(rr_rd),
    .rr_imm32(rr_imm32), .rr_rs1(rr_rs1), .rr_rs2(rr_rs2), .rr_hazard_cnt(rr_hazard_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic fwd(input int k, input logic v, input logic r, input logic [4:0] rg, input logic [XLEN-1:0] val);
    fwd_valid[k] = v;
    fwd_ready[k] = r;
    fwd_reg[5*k +: 5] = rg;
    fwd_val[XLEN*k +: XLEN] = val;
    #1;
  endtask

  task automatic dec(input logic [XLEN-1:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic u1, input logic u2);
    decode_valid = 1'b1;
    decode_pc = pc;
    decode_inst = 32'h00A282B3;
    decode_opcode = 7'h33;
    decode_funct3 = 3'h0;
    decode_funct7 = 7'h00;
    decode_rd = 5'd5;
    decode_imm32 = 32'h0000_0123;
    decode_rs1 = rs1;
    decode_rs2 = rs2;
    decode_uses_rs1 = u1;
    decode_uses_rs2 = u2;
    #1;
  endtask

  initial begin
    i_reset = 1'b1; i_pipe_stall = 1'b0; i_pipe_flush = 1'b0; decode_valid = 1'b0;
    decode_pc = '0; decode_imm32 = '0; decode_inst = '0; decode_opcode = '0; decode_funct3 = '0;
    decode_funct7 = '0; decode_rs1 = '0; decode_rs2 = '0; decode_rd = '0;
    decode_uses_rs1 = 1'b0; decode_uses_rs2 = 1'b0;
    data_p1 = 32'h1111; data_p2 = 32'h2222;
    fwd_valid = '0; fwd_ready = '0; fwd_reg = '0; fwd_val = '0;
    tick; tick;
    chk("reset_valid", rr_valid, 0);
    chk("reset_cnt", rr_hazard_cnt, 0);
    chk("reset_rs1", rr_rs1, 0);
    chk("reset_pc", rr_pc, 0);
    i_reset = 1'b0;
    // forwarding priority: youngest entry wins
    dec(32'h40, 5'd5, 5'd9, 1'b1, 1'b1);
    fwd(0, 1'b1, 1'b1, 5'd5, 32'hAAAA);
    fwd(1, 1'b1, 1'b1, 5'd5, 32'hBBBB);
    chk("read_p1", read_p1, 5);
    chk("read_p2", read_p2, 9);
    chk("prio_nostall", o_decode_stall, 0);
    tick;
    chk("prio_valid", rr_valid, 1);
    chk("prio_rs1", rr_rs1, 32'hAAAA);
    chk("prio_rs2_rf", rr_rs2, 32'h2222);
    chk("prio_pc", rr_pc, 32'h40);
    chk("prio_inst", rr_inst, 32'h00A282B3);
    chk("prio_imm", rr_imm32, 32'h123);
    chk("prio_rd", rr_rd, 5);
    chk("prio_opcode", rr_opcode, 7'h33);
    // only the older entry matches
    fwd(0, 1'b1, 1'b1, 5'd3, 32'hCCCC);
    tick;
    chk("older_rs1", rr_rs1, 32'hBBBB);
    // load-use on rs2 for two cycles
    dec(32'h44, 5'd1, 5'd7, 1'b1, 1'b1);
    fwd(0, 1'b1, 1'b0, 5'd7, 32'h7777);
    fwd(1, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("lu_stall1", o_decode_stall, 1);
    tick;
    chk("lu_bubble1", rr_valid, 0);
    chk("lu_cnt1", rr_hazard_cnt, 1);
    chk("lu_stall2", o_decode_stall, 1);
    tick;
    chk("lu_bubble2", rr_valid, 0);
    chk("lu_bubble2_pc", rr_pc, 0);
    chk("lu_cnt2", rr_hazard_cnt, 2);
    fwd(0, 1'b1, 1'b1, 5'd7, 32'h7777);
    chk("lu_release", o_decode_stall, 0);
    tick;
    chk("lu_valid", rr_valid, 1);
    chk("lu_rs2", rr_rs2, 32'h7777);
    chk("lu_rs1_rf", rr_rs1, 32'h1111);
    chk("lu_cnt_hold", rr_hazard_cnt, 2);
    // older ready match must not hide a younger pending one
    dec(32'h48, 5'd5, 5'd9, 1'b1, 1'b0);
    fwd(0, 1'b1, 1'b0, 5'd5, 32'h5);
    fwd(1, 1'b1, 1'b1, 5'd5, 32'h6);
    chk("shadow_stall", o_decode_stall, 1);
    tick;
    chk("shadow_cnt", rr_hazard_cnt, 3);
    // x0 and unused operand never stall; operands still resolved
    dec(32'h4C, 5'd0, 5'd7, 1'b1, 1'b0);
    fwd(0, 1'b1, 1'b0, 5'd0, 32'hDEAD);
    fwd(1, 1'b1, 1'b0, 5'd7, 32'hBEEF);
    chk("x0_nostall", o_decode_stall, 0);
    tick;
    chk("x0_valid", rr_valid, 1);
    chk("x0_rs1", rr_rs1, 0);
    chk("unused_rs2", rr_rs2, 32'hBEEF);
    chk("x0_cnt", rr_hazard_cnt, 3);
    // empty decode slot captures zeros
    decode_valid = 1'b0;
    #1;
    chk("empty_nostall", o_decode_stall, 0);
    tick;
    chk("empty_valid", rr_valid, 0);
    chk("empty_pc", rr_pc, 0);
    // capture, then stall with hazard holds everything
    fwd(0, 1'b0, 1'b0, 5'd0, 32'h0);
    fwd(1, 1'b0, 1'b0, 5'd0, 32'h0);
    dec(32'h100, 5'd2, 5'd3, 1'b1, 1'b1);
    tick;
    chk("pre_stall_pc", rr_pc, 32'h100);
    fwd(0, 1'b1, 1'b0, 5'd2, 32'h9);
    dec(32'h104, 5'd2, 5'd3, 1'b1, 1'b1);
    i_pipe_stall = 1'b1;
    #1;
    chk("stall_out", o_decode_stall, 1);
    tick;
    chk("stall_valid", rr_valid, 1);
    chk("stall_pc", rr_pc, 32'h100);
    chk("stall_cnt", rr_hazard_cnt, 3);
    // flush beats stall and hazard
    i_pipe_flush = 1'b1;
    #1;
    chk("flush_nostall", o_decode_stall, 0);
    tick;
    chk("flush_valid", rr_valid, 0);
    chk("flush_pc", rr_pc, 0);
    chk("flush_cnt", rr_hazard_cnt, 3);
    i_pipe_flush = 1'b0;
    i_pipe_stall = 1'b0;
    // saturation via backdoor preload
    force dut.rr_hazard_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.rr_hazard_cnt;
    #1;
    chk("preload", rr_hazard_cnt, 32'hFFFF_FFFE);
    tick;
    chk("sat_reach", rr_hazard_cnt, 32'hFFFF_FFFF);
    tick;
    chk("sat_hold", rr_hazard_cnt, 32'hFFFF_FFFF);
    // reset mid-hazard clears the counter
    i_reset = 1'b1;
    #1;
    tick;
    chk("rst_cnt", rr_hazard_cnt, 0);
    chk("rst_valid", rr_valid, 0);
    i_reset = 1'b0;
    tick;
    chk("post_rst_cnt", rr_hazard_cnt, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule

// File: doc/tiny_rv_rr_hz.md
TINY_RV_RR_HZ -- requirements
Module: tiny_rv_rr_hz

Interface
REQ-001 Parameter XLEN, default 32, datapath and operand width.
REQ-002 Parameter NUM_FWD, default 2, number of forwarding sources; index 0 is the youngest and has the highest priority.
REQ-003 i_clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 i_reset  in  1  synchronous, active-high reset.
REQ-005 i_pipe_stall  in  1  downstream stall; hold all registered outputs.
REQ-006 i_pipe_flush  in  1  discard the in-flight instruction.
REQ-007 decode_valid  in  1  decode slot holds an instruction.
REQ-008 decode_pc / decode_imm32  in  XLEN each  PC and immediate.
REQ-009 decode_inst  in  32  raw instruction.
REQ-010 decode_opcode 7, decode_funct3 3, decode_funct7 7  in  decoded fields.
REQ-011 decode_rs1 / decode_rs2 / decode_rd  in  5 each  register indices.
REQ-012 decode_uses_rs1 / decode_uses_rs2  in  1 each  operand is actually read.
REQ-013 read_p1 / read_p2  out  5 each  register-file read addresses.
REQ-014 data_p1 / data_p2  in  XLEN each  register-file read data, same cycle.
REQ-015 fwd_valid  in  NUM_FWD  forwarding entry k is live.
REQ-016 fwd_ready  in  NUM_FWD  value of entry k is available; 0 means a load is still pending.
REQ-017 fwd_reg  in  NUM_FWD*5  destination register per entry, packed with k at bits [5k+4:5k].
REQ-018 fwd_val  in  NUM_FWD*XLEN  forwarded value per entry, packed in the same way.
REQ-019 o_decode_stall  out  1  decode and fetch must hold this cycle.
REQ-020 rr_valid  out  1  registered outputs carry a real instruction.
REQ-021 rr_pc, rr_inst, rr_opcode, rr_funct3, rr_funct7, rr_rd, rr_imm32  out  same widths as the decode fields.
REQ-022 rr_rs1 / rr_rs2  out  XLEN each  resolved operands.
REQ-023 rr_hazard_cnt  out  32  saturating count of inserted hazard bubbles.

Function
REQ-024 read_p1 SHALL equal decode_rs1 and read_p2 SHALL equal decode_rs2, combinationally.
REQ-025 Operand resolution, per operand: rs==0 gives 0; else the first (lowest) k with fwd_valid[k] and fwd_reg[k]==rs gives fwd_val[k]; else the register-file data.
REQ-026 An operand hazard SHALL exist when all of these hold:
- decode_valid and uses_rsX are set;
- rs is not 0;
- the first matching entry k has fwd_ready[k]==0.
An older ready match SHALL NOT clear the hazard. hazard is the OR of both operands.
REQ-027 Define o_decode_stall = !i_pipe_flush && (i_pipe_stall || hazard), combinational.
REQ-028 Per-edge update priority SHALL be: i_reset > i_pipe_flush > i_pipe_stall > hazard > capture.
REQ-029 Flush: rr_valid and all payload outputs go to 0; rr_hazard_cnt holds.
REQ-030 Stall: all rr_* outputs and rr_hazard_cnt hold.
REQ-031 Hazard (no stall, no flush): bubble inserted; rr_valid and payload go to 0; rr_hazard_cnt increments by 1, saturating at 0xFFFFFFFF.
REQ-032 Capture: rr_valid <= decode_valid; payload and resolved operands <= decode values when decode_valid=1, else all 0.
REQ-033 Latency SHALL be one cycle from decode inputs to rr_* outputs.
REQ-034 Forwarding matches SHALL NOT depend on decode_uses_rsX; operands are resolved even when unused.
REQ-035 A fwd entry with fwd_reg==0 SHALL never match and SHALL never cause a hazard.
REQ-036 The block SHALL be correct for any NUM_FWD>=1 and any XLEN>=32; all comparisons are on 5-bit indices.

Reset
REQ-037 On i_reset every output register SHALL be 0: rr_valid, all payload, rr_rs1, rr_rs2 and rr_hazard_cnt.
REQ-038 Reset SHALL take priority over simultaneous flush, stall or hazard.
REQ-039 Reset mid-hazard SHALL leave rr_hazard_cnt at 0 on the following cycle.

Verification
REQ-040 Forwarding priority: rs1=5, fwd0={v,r,reg5,0xAAAA}, fwd1={v,r,reg5,0xBBBB} -> next cycle rr_rs1=0xAAAA, rr_valid=1.
REQ-041 Load-use: rs2=7, uses_rs2=1, fwd0={v,!r,reg7} for 2 cycles, then r=1 -> o_decode_stall=1 for those 2 cycles, 2 bubbles, rr_hazard_cnt=2, then rr_rs2=fwd_val0.
REQ-042 x0 and unused operands: rs1=0 with a not-ready entry on reg0, and rs2 not-ready with uses_rs2=0 -> no stall, rr_rs1=0.
REQ-043 Stall vs flush vs hazard: i_pipe_stall with hazard -> outputs hold, counter holds; i_pipe_flush with hazard -> rr_valid=0, o_decode_stall=0.
REQ-044 Saturation: preload counter by forcing 0xFFFFFFFF hazards (or via bench backdoor), one more hazard -> rr_hazard_cnt stays 0xFFFFFFFF; i_reset -> 0.
